axi4_reader: RTL and testbench
==============================

AXI4_READER -- requirements
Module: axi4_reader

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width.
- BURST_BYTES, 512, bytes per burst (64 beats x 8 B).
- FRAME_BYTES, 153600, bytes per frame (320x240 RGB565).

REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk_100Mhz, in, 1, sole clock; all logic is on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle pulse that begins reading one frame.
- FRAME_BASE_ADDR, in, 32, frame buffer base address; sampled on an accepted frame_start.
- ARADDR, out, 32, read burst address.
- ARVALID, out, 1, read address valid.
- ARREADY, in, 1, read address ready.
- ARLEN, out, 8, constant 63.
- ARSIZE, out, 3, constant 3'b011.
- ARBURST, out, 2, constant 2'b01 (INCR).
- ARCACHE, out, 4, constant 4'b0011.
- ARPROT, out, 3, constant 3'b000.
- RDATA, in, 64, read data.
- RVALID, in, 1, read data valid.
- RREADY, out, 1, read data ready.
- RLAST, in, 1, last beat of burst.
- RRESP, in, 2, read response.
- m_data, out, 64, output stream word toward the HDMI-side CDC FIFO.
- m_valid, out, 1, m_data valid.
- m_ready, in, 1, downstream accept.
- m_last, out, 1, high with the final word of the frame.
- reader_done, out, 1, one-cycle pulse when the final burst of a frame completes.
- rd_error, out, 1, sticky AXI/protocol error flag.
- state, out, 2, current FSM state.
- ADDR_OFFSET, out, 32, byte offset of the current burst.

Function
REQ-003 SHALL contain a synchronous 128-entry x 65-bit FWFT FIFO ({frame_last, data}) with an 8-bit occupancy count.
REQ-004 SHALL drive m_valid = FIFO not empty; pop occurs on m_valid && m_ready; push on RVALID && RREADY.
REQ-005 SHALL implement FSM states IDLE=0, ADDR_SEND=1, DATA_RECV=2, NEXT=3.
REQ-006 IDLE handling of frame_start:
- frame_start when not active SHALL set active, latch FRAME_BASE_ADDR, and clear ADDR_OFFSET.
- frame_start while active SHALL be ignored.
REQ-007 IDLE -> ADDR_SEND SHALL occur when active and free entries >= 64 (occupancy <= 64); ARADDR SHALL load base + ADDR_OFFSET on this transition.
REQ-008 In ADDR_SEND, ARVALID SHALL be 1 and ARADDR stable until the ARVALID && ARREADY cycle, after which ARVALID=0 and state = DATA_RECV.
REQ-009 RREADY SHALL be 1 only in DATA_RECV; the reserved 64 entries guarantee no overflow.
REQ-010 DATA_RECV SHALL count accepted beats 0..63 and go to NEXT on the accepted beat where count==63.
REQ-011 rd_error SHALL set on either condition:
- an accepted beat with RRESP != 0;
- an accepted beat where RLAST != (count==63).
REQ-012 NEXT handling, one cycle, then IDLE:
- if ADDR_OFFSET == FRAME_BYTES-BURST_BYTES (153088), SHALL pulse reader_done, clear active, and clear ADDR_OFFSET;
- otherwise, ADDR_OFFSET += 512.
REQ-013 The frame_last bit SHALL be pushed as 1 only on beat 63 of the burst at offset 153088; m_last = frame_last of the FIFO head.
REQ-014 Simultaneous push and pop SHALL leave the count unchanged; a pop on empty or a push on full SHALL never occur.
REQ-015 Total words per frame SHALL be 19200; ARADDR SHALL be 512-byte aligned relative to base.

Reset
REQ-016 On rst_n=0, asynchronously: state=IDLE, FIFO empty, m_valid=0, m_last=0, ARVALID=0, RREADY=0, ARADDR=0, ADDR_OFFSET=0, active=0, reader_done=0, rd_error=0, beat count 0.
REQ-017 Reset mid-burst SHALL abandon the burst and discard FIFO contents; after release, no AR SHALL issue until a new frame_start.

Verification
REQ-018 Single burst: base 0x1000_0000, frame_start, ARREADY delayed 3 cycles, 64 beats, m_ready=1 -> ARADDR 0x1000_0000 held for 3 cycles; 64 words out in order; state 0-1-2-3-0.
REQ-019 Backpressure: m_ready=0 for the whole test -> exactly 2 ARs issued (offsets 0, 512); no third AR until occupancy <= 64; no words lost after m_ready=1.
REQ-020 Full frame: 300 bursts -> last ARADDR = base+153088; reader_done pulses once; m_last on word 19200 only; ADDR_OFFSET returns to 0.
REQ-021 Error: RRESP=2'b10 on beat 5 -> rd_error=1 and remains set; frame completes normally.
REQ-022 frame_start pulsed mid-frame -> ignored; base unchanged; burst count still 300.
REQ-023 rst_n low during beat 30 -> all outputs at reset values immediately; no AR after release until frame_start.

Source files
------------

// File: rtl/axi4_reader.sv
// rtl/axi4_reader.sv - AXI4 burst reader feeding a 128-deep FWFT FIFO toward the HDMI-side stream.
// A burst is only requested when 64 FIFO entries are free, so RREADY can stay high for the whole burst.
module axi4_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_BYTES    = 512,
  parameter int FRAME_BYTES    = 153600
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      reader_done,
  output logic                      rd_error,
  output logic [1:0]                state,
  output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

  localparam int BEATS  = BURST_BYTES / (AXI_DATA_WIDTH / 8);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int DEPTH  = 128;
  localparam int PTR_W  = 7;
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_OFF  = AXI_ADDR_WIDTH'(FRAME_BYTES - BURST_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP      = AXI_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [7:0]                MAX_FILL  = 8'(DEPTH - BEATS);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_SEND = 2'd1, DATA_RECV = 2'd2, NEXT = 2'd3} state_e;

  state_e                    state_q, state_d;
  logic                      active_q, active_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [AXI_DATA_WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [7:0]                count_q;
  logic                      push, pop, push_last;
  logic [AXI_DATA_WIDTH:0]   head;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    base_d   = base_q;
    offset_d = offset_q;
    araddr_d = araddr_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (active_q && count_q <= MAX_FILL) begin
          state_d  = ADDR_SEND;
          araddr_d = base_q + offset_q;
        end
      end
      ADDR_SEND: begin
        if (ARREADY) state_d = DATA_RECV;
      end
      DATA_RECV: begin
        if (RVALID) begin
          beat_d = beat_q + 1'b1;
          if (RRESP != 2'b00 || RLAST != (beat_q == LAST_BEAT)) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = IDLE;
        if (offset_q == LAST_OFF) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          offset_d = '0;
        end else begin
          offset_d = offset_q + STEP;
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame is in flight whenever active is set; new starts are only taken between frames.
    if (frame_start && !active_q) begin
      active_d = 1'b1;
      base_d   = FRAME_BASE_ADDR;
      offset_d = '0;
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      base_q   <= '0;
      offset_q <= '0;
      araddr_q <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign push      = RVALID && RREADY;
  assign pop       = m_valid && m_ready;
  assign push_last = (beat_q == LAST_BEAT) && (offset_q == LAST_OFF);

  always_ff @(posedge clk_100Mhz) begin
    if (push) mem[wr_ptr_q] <= {push_last, RDATA};
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 8'd1;
        2'b01:   count_q <= count_q - 8'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head        = mem[rd_ptr_q];
  assign m_valid     = (count_q != 8'd0);
  assign m_data      = head[AXI_DATA_WIDTH-1:0];
  assign m_last      = m_valid && head[AXI_DATA_WIDTH];

  assign ARADDR      = araddr_q;
  assign ARVALID     = (state_q == ADDR_SEND);
  assign RREADY      = (state_q == DATA_RECV);
  assign ARLEN       = 8'(BEATS - 1);
  assign ARSIZE      = 3'b011;
  assign ARBURST     = 2'b01;
  assign ARCACHE     = 4'b0011;
  assign ARPROT      = 3'b000;
  assign reader_done = done_q;
  assign rd_error    = err_q;
  assign state       = state_q;
  assign ADDR_OFFSET = offset_q;

endmodule

// File: tb/tb_axi4_reader.sv
// tb/tb_axi4_reader.sv - Randomized AXI slave and stream sink checked against an address-arithmetic frame model.
module tb_axi4_reader;
  localparam int FRAME_WORDS = 19200;
  localparam int BURSTS      = 300;

  logic        clk_100Mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] FRAME_BASE_ADDR = '0;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [1:0]  RRESP;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        reader_done;
  logic        rd_error;
  logic [1:0]  state;
  logic [31:0] ADDR_OFFSET;

  axi4_reader dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .frame_start(frame_start),
    .FRAME_BASE_ADDR(FRAME_BASE_ADDR), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .reader_done(reader_done), .rd_error(rd_error), .state(state), .ADDR_OFFSET(ADDR_OFFSET)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_base = '0;
  int          words_seen = 0;
  int          m_last_seen = 0;
  int          ar_count = 0;
  logic [31:0] last_araddr = '0;
  logic [31:0] ar_hold = '0;
  int          ar_wait = 0;
  int          ar_delay = 3;
  int          first_wait = -1;
  int          done_pulses = 0;
  int          cur_beat = 0;
  int          pres_beat = -1;
  logic [31:0] burst_q[$];
  bit          r_gap_en = 1'b0;
  bit          inject_err = 1'b0;
  int          m_mode = 1;

  function automatic logic [63:0] ref_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI read slave: R is handled before AR so a new burst's data starts after its handshake.
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    forever begin
      @(posedge clk_100Mhz); #1;
      if (!rst_n) begin
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        burst_q.delete(); cur_beat = 0; pres_beat = -1; ar_wait = 0;
        continue;
      end
      if (burst_q.size() != 0) begin
        RVALID    = r_gap_en ? ($urandom_range(0, 7) != 0) : 1'b1;
        RDATA     = ref_word(burst_q[0] + 32'(cur_beat * 8));
        RLAST     = (cur_beat == 63);
        RRESP     = (inject_err && cur_beat == 5) ? 2'b10 : 2'b00;
        pres_beat = cur_beat;
        if (RVALID && RREADY) begin
          if (cur_beat == 5) inject_err = 1'b0;
          if (cur_beat == 63) begin
            void'(burst_q.pop_front());
            cur_beat = 0;
          end else cur_beat++;
        end
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; pres_beat = -1;
      end
      if (ARVALID) begin
        if (ar_wait > 0) chk("araddr_stable", ARADDR, ar_hold);
        ar_hold = ARADDR;
        ARREADY = (ar_wait >= ar_delay);
        if (ARREADY) begin
          chk("araddr", ARADDR, exp_base + 32'(ar_count * 512));
          if (first_wait < 0) first_wait = ar_wait;
          burst_q.push_back(ARADDR);
          last_araddr = ARADDR;
          ar_count++;
          ar_wait = 0;
          ar_delay = $urandom_range(0, 3);
        end else ar_wait++;
      end else ARREADY = 1'b0;
    end
  end

  // Stream sink: word w of a frame must carry the data stored at base + 8*w.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk_100Mhz); #1;
      if (!rst_n) begin
        m_ready = 1'b0;
        continue;
      end
      case (m_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 7) != 0);
      endcase
      if (m_valid && m_ready) begin
        chk("m_data", m_data, ref_word(exp_base + 32'(words_seen * 8)));
        chk("m_last", {63'd0, m_last}, {63'd0, words_seen == FRAME_WORDS - 1});
        if (m_last) m_last_seen++;
        words_seen++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_100Mhz); #1;
      if (reader_done) done_pulses++;
    end
  end

  initial begin
    int seq[$];
    int prev;
    int snap;
    bit got;

    repeat (3) @(posedge clk_100Mhz);
    #1;
    chk("rst_state", state, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_offset", ADDR_OFFSET, 0);
    chk("rst_done", reader_done, 0);
    chk("rst_error", rd_error, 0);
    chk("arlen", ARLEN, 63);
    chk("arsize", ARSIZE, 3'b011);
    chk("arburst", ARBURST, 2'b01);
    chk("arcache", ARCACHE, 4'b0011);
    chk("arprot", ARPROT, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_100Mhz);
    #1;

    // Full frame: deterministic first burst, then random timing, an error beat and a stray frame_start.
    exp_base = 32'h1000_0000; ar_count = 0; words_seen = 0; m_last_seen = 0; done_pulses = 0;
    ar_delay = 3; first_wait = -1; inject_err = 1'b1; m_mode = 1; r_gap_en = 1'b0;
    FRAME_BASE_ADDR = exp_base; frame_start = 1'b1;
    @(posedge clk_100Mhz); #1;
    frame_start = 1'b0; FRAME_BASE_ADDR = $urandom;
    prev = state;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_100Mhz); #1;
      if (state != prev) seq.push_back(int'(state));
      prev = state;
      if (state == 0 && seq.size() > 0) break;
    end
    chk("seq_len", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("seq0", seq[0], 1);
      chk("seq1", seq[1], 2);
      chk("seq2", seq[2], 3);
      chk("seq3", seq[3], 0);
    end
    chk("first_ar_wait", first_wait, 3);
    chk("offset_after_b0", ADDR_OFFSET, 512);
    chk("err_after_b0", rd_error, 1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk_100Mhz); #1;
      got = (words_seen >= 64);
    end
    chk("b0_words", got, 1);

    r_gap_en = 1'b1; m_mode = 2;
    got = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      @(posedge clk_100Mhz); #1;
      got = (ar_count >= 150);
    end
    chk("mid_frame_reached", got, 1);
    FRAME_BASE_ADDR = 32'h2000_0000; frame_start = 1'b1;
    @(posedge clk_100Mhz); #1;
    frame_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40000 && !got; i++) begin
      @(posedge clk_100Mhz); #1;
      got = (done_pulses >= 1);
    end
    chk("done_seen", got, 1);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk_100Mhz); #1;
      got = (words_seen >= FRAME_WORDS);
    end
    chk("frame_drained", got, 1);
    repeat (20) @(posedge clk_100Mhz);
    #1;
    chk("burst_count", ar_count, BURSTS);
    chk("last_araddr", last_araddr, exp_base + 32'd153088);
    chk("done_pulses", done_pulses, 1);
    chk("m_last_count", m_last_seen, 1);
    chk("frame_words", words_seen, FRAME_WORDS);
    chk("offset_end", ADDR_OFFSET, 0);
    chk("state_end", state, 0);
    chk("err_sticky", rd_error, 1);
    chk("idle_no_ar", ARVALID, 0);
    chk("idle_empty", m_valid, 0);

    // Backpressure: with the sink stalled only two bursts fit under the reservation rule.
    rst_n = 1'b0;
    repeat (2) @(posedge clk_100Mhz);
    #1;
    chk("err_cleared", rd_error, 0);
    rst_n = 1'b1;
    m_mode = 0; r_gap_en = 1'b1;
    exp_base = $urandom & 32'hFFFF_FE00; ar_count = 0; words_seen = 0; ar_delay = $urandom_range(0, 3);
    @(posedge clk_100Mhz); #1;
    FRAME_BASE_ADDR = exp_base; frame_start = 1'b1;
    @(posedge clk_100Mhz); #1;
    frame_start = 1'b0;
    repeat (400) @(posedge clk_100Mhz);
    #1;
    chk("bp_ar_count", ar_count, 2);
    chk("bp_last_araddr", last_araddr, exp_base + 32'd512);
    chk("bp_offset", ADDR_OFFSET, 1024);
    chk("bp_state", state, 0);
    chk("bp_m_valid", m_valid, 1);
    m_mode = 1;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk_100Mhz); #1;
      got = (words_seen >= 200);
    end
    chk("bp_drain", got, 1);
    chk("bp_third_ar", ar_count >= 3, 1);

    // Reset in the middle of beat 30 of the burst in flight.
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk_100Mhz); #2;
      got = (RVALID && pres_beat == 30);
    end
    chk("beat30_reached", got, 1);
    chk("beat30_state", state, 2);
    rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_arvalid", ARVALID, 0);
    chk("ar_rready", RREADY, 0);
    chk("ar_m_valid", m_valid, 0);
    chk("ar_m_last", m_last, 0);
    chk("ar_araddr", ARADDR, 0);
    chk("ar_offset", ADDR_OFFSET, 0);
    chk("ar_done", reader_done, 0);
    chk("ar_error", rd_error, 0);
    repeat (2) @(posedge clk_100Mhz);
    #1;
    rst_n = 1'b1;
    snap = ar_count;
    repeat (100) @(posedge clk_100Mhz);
    #1;
    chk("post_rst_no_ar", ar_count, snap);
    chk("post_rst_state", state, 0);
    chk("post_rst_empty", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
